// File: rtl/zeroriscy_host_if.sv
// Host-interface monitor for a zeroriscy core. Watches the data bus for
// tohost pass/fail writes on up to four channels, buffers console bytes in a
// small FIFO and optionally ends the run with a cycle watchdog.
module zeroriscy_host_if #(
  parameter int          NUM_TOHOST   = 3,
  parameter logic [31:0] TOHOST_ADDR0 = 32'h80001000,
  parameter logic [31:0] TOHOST_ADDR1 = 32'h80003000,
  parameter logic [31:0] TOHOST_ADDR2 = 32'h8017fffc,
  parameter logic [31:0] TOHOST_ADDR3 = 32'h0,
  parameter logic [31:0] CONSOLE_ADDR = 32'h9a100000,
  parameter int          CON_DEPTH    = 16,
  parameter logic [63:0] MAX_CYCLES   = 64'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [30:0] fail_code_o,
  output logic [1:0]  fail_chan_o,
  output logic [63:0] cycle_cnt_o,
  output logic [15:0] con_drop_o,
  output logic [1:0]  state_o
);

  localparam int AW = $clog2(CON_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t      state;
  logic        wr_cyc;
  logic [31:0] tohost_addr [4];
  logic        tohost_hit;
  logic [1:0]  tohost_chan;
  logic        hit_q;
  logic [31:0] hit_data_q;
  logic [1:0]  hit_chan_q;
  logic [63:0] cnt_next;

  logic [7:0]  con_mem [CON_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        con_empty;
  logic        con_full;
  logic        con_push_req;
  logic        con_push;
  logic        con_pop;
  logic        con_drop_evt;

  // Only byte lane 0 carries console data; the other enables are don't-care.
  logic unused_be;
  assign unused_be = ^data_be_i[3:1];

  assign wr_cyc = data_req_i & data_we_i;

  assign tohost_addr[0] = TOHOST_ADDR0;
  assign tohost_addr[1] = TOHOST_ADDR1;
  assign tohost_addr[2] = TOHOST_ADDR2;
  assign tohost_addr[3] = TOHOST_ADDR3;

  // Channel decode: scanning downwards lets the lowest matching index win.
  always_comb begin
    tohost_hit  = 1'b0;
    tohost_chan = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((i < NUM_TOHOST) && wr_cyc && (data_addr_i == tohost_addr[i])) begin
        tohost_hit  = 1'b1;
        tohost_chan = 2'(i);
      end
    end
  end

  // Register non-zero tohost writes; the FSM acts on them one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q      <= 1'b0;
      hit_data_q <= 32'd0;
      hit_chan_q <= 2'd0;
    end else begin
      hit_q <= tohost_hit && (data_wdata_i != 32'd0);
      if (tohost_hit && (data_wdata_i != 32'd0)) begin
        hit_data_q <= data_wdata_i;
        hit_chan_q <= tohost_chan;
      end
    end
  end

  assign cnt_next = cycle_cnt_o + 64'd1;

  // Run-state FSM: a registered hit beats the watchdog; terminal states hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_RUN;
      cycle_cnt_o <= 64'd0;
      fail_code_o <= 31'd0;
      fail_chan_o <= 2'd0;
    end else begin
      case (state)
        ST_RUN: begin
          cycle_cnt_o <= cnt_next;
          if (hit_q) begin
            if (hit_data_q == 32'd1) begin
              state <= ST_PASS;
            end else begin
              state       <= ST_FAIL;
              fail_code_o <= hit_data_q[31:1];
              fail_chan_o <= hit_chan_q;
            end
          end else if ((MAX_CYCLES != 64'd0) && (cnt_next > MAX_CYCLES)) begin
            state <= ST_TIMEOUT;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign state_o   = state;
  assign done_o    = (state != ST_RUN);
  assign pass_o    = (state == ST_PASS);
  assign fail_o    = (state == ST_FAIL);
  assign timeout_o = (state == ST_TIMEOUT);

  // Console handshake: a byte transfers on every rising edge where
  // con_valid_o and con_ready_i are both high; con_data_o is stable while
  // con_valid_o is high and not yet accepted. A push into an empty FIFO is
  // only visible the following cycle (no bypass).
  assign con_empty    = (wr_ptr == rd_ptr);
  assign con_full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign con_valid_o  = !con_empty;
  assign con_data_o   = con_mem[rd_ptr[AW-1:0]];
  assign con_pop      = con_valid_o & con_ready_i;
  assign con_push_req = wr_cyc && (data_addr_i == CONSOLE_ADDR) && data_be_i[0];
  assign con_push     = con_push_req && (!con_full || con_pop);
  assign con_drop_evt = con_push_req && con_full && !con_pop;

  // FIFO pointers and saturating drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      con_drop_o <= 16'd0;
    end else begin
      if (con_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (con_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (con_drop_evt && (con_drop_o != 16'hFFFF)) con_drop_o <= con_drop_o + 16'd1;
    end
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk_i) begin
    if (con_push) con_mem[wr_ptr[AW-1:0]] <= data_wdata_i[7:0];
  end

endmodule

// File: tb/tb_zeroriscy_host_if.sv
// Directed bench for zeroriscy_host_if with a console scoreboard.
module tb_zeroriscy_host_if;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] TH0      = 32'h80001000;
  localparam logic [31:0] TH2      = 32'h8017fffc;
  localparam logic [31:0] CON_ADDR = 32'h9a100000;

  logic        clk;
  logic        rst_n;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [30:0] fail_code;
  logic [1:0]  fail_chan;
  logic [63:0] cycle_cnt;
  logic [15:0] con_drop;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  zeroriscy_host_if #(
    .CON_DEPTH  (DEPTH),
    .MAX_CYCLES (64'd100)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_req_i   (data_req),
    .data_we_i    (data_we),
    .data_be_i    (data_be),
    .data_addr_i  (data_addr),
    .data_wdata_i (data_wdata),
    .con_valid_o  (con_valid),
    .con_data_o   (con_data),
    .con_ready_i  (con_ready),
    .done_o       (done),
    .pass_o       (pass),
    .fail_o       (fail),
    .timeout_o    (timeout),
    .fail_code_o  (fail_code),
    .fail_chan_o  (fail_chan),
    .cycle_cnt_o  (cycle_cnt),
    .con_drop_o   (con_drop),
    .state_o      (state)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL time_limit: observed no end of run, expected $finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'hF;
    data_addr  = addr;
    data_wdata = wdata;
    tick();
    data_req = 1'b0;
    data_we  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"},     64'(state), 64'd0);
    check({tag, "_done"},      64'(done), 64'd0);
    check({tag, "_pass"},      64'(pass), 64'd0);
    check({tag, "_fail"},      64'(fail), 64'd0);
    check({tag, "_timeout"},   64'(timeout), 64'd0);
    check({tag, "_fail_code"}, 64'(fail_code), 64'd0);
    check({tag, "_fail_chan"}, 64'(fail_chan), 64'd0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 64'd0);
    check({tag, "_con_drop"},  64'(con_drop), 64'd0);
    check({tag, "_con_valid"}, 64'(con_valid), 64'd0);
  endtask

  // One console cycle: scoreboard pops on handshake, pushes accepted bytes.
  task automatic con_step(input logic push, input logic [7:0] b,
                          input logic [3:0] be, input logic rdy);
    logic [7:0] exp_b;
    con_ready  = rdy;
    data_req   = push;
    data_we    = push;
    data_be    = be;
    data_addr  = CON_ADDR;
    data_wdata = {24'h0, b};
    check("con_valid", 64'(con_valid), 64'(exp_q.size() > 0));
    if (rdy && (exp_q.size() > 0)) begin
      exp_b = exp_q.pop_front();
      check("con_data", 64'(con_data), 64'(exp_b));
    end
    if (push && be[0] && (exp_q.size() < DEPTH)) exp_q.push_back(b);
    tick();
    data_req  = 1'b0;
    data_we   = 1'b0;
    con_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) con_step(1'b0, 8'h00, 4'h0, 1'b1);
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(con_valid), 64'd0);
  endtask

  task automatic wait_cnt(input logic [63:0] target);
    for (int i = 0; i < 300; i++) begin
      if (cycle_cnt === target) return;
      tick();
    end
    check("wait_cnt", cycle_cnt, target);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Directed sequence
  initial begin
    logic [63:0] frozen;
    rst_n      = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    con_ready  = 1'b0;
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("first_count", cycle_cnt, 64'd1);

    // Pass on channel 0: write in cycle N, pass visible from N+2
    wr(TH0, 32'd1);
    check("pass_n1", 64'(pass), 64'd0);
    tick();
    check("pass_n2", 64'(pass), 64'd1);
    check("pass_done", 64'(done), 64'd1);
    check("pass_cnt", cycle_cnt, 64'd3);
    frozen = cycle_cnt;
    tick(); tick(); tick();
    check("pass_frozen", cycle_cnt, frozen);
    check("pass_no_fail", 64'(fail), 64'd0);

    // Fail on channel 2, zero write ignored, later pass write ignored
    reset_pulse();
    wr(TH2, 32'd0);
    tick(); tick();
    check("zero_ignored", 64'(state), 64'd0);
    wr(TH2, 32'h0000000B);
    tick();
    check("fail_flag", 64'(fail), 64'd1);
    check("fail_code", 64'(fail_code), 64'd5);
    check("fail_chan", 64'(fail_chan), 64'd2);
    wr(TH0, 32'd1);
    tick(); tick();
    check("fail_hold", 64'(fail), 64'd1);
    check("fail_no_pass", 64'(pass), 64'd0);
    check("fail_code_hold", 64'(fail_code), 64'd5);
    check("fail_chan_hold", 64'(fail_chan), 64'd2);

    // Console "ABCDEF" into depth 4 with consumer stalled
    for (int i = 0; i < 6; i++) con_step(1'b1, 8'(8'h41 + i), 4'b0001, 1'b0);
    check("drop_two", 64'(con_drop), 64'd2);
    drain();

    // No bypass on empty FIFO
    con_step(1'b1, 8'h51, 4'b0001, 1'b1);
    check("nobypass_valid", 64'(con_valid), 64'd1);
    check("nobypass_data", 64'(con_data), 64'h51);
    drain();

    // Full FIFO with simultaneous push and pop, then ignored lane-0-less push
    for (int i = 0; i < 4; i++) con_step(1'b1, 8'(8'h57 + i), 4'b0001, 1'b0);
    con_step(1'b1, 8'h31, 4'b0001, 1'b1);
    check("full_pushpop_drop", 64'(con_drop), 64'd2);
    check("full_occupancy", 64'(exp_q.size()), 64'd4);
    con_step(1'b1, 8'h48, 4'b1110, 1'b0);
    check("be_ignored_drop", 64'(con_drop), 64'd2);
    drain();

    // Reset in FAIL with three bytes buffered
    for (int i = 0; i < 3; i++) con_step(1'b1, 8'(8'h61 + i), 4'b0001, 1'b0);
    check("pre_reset_fail", 64'(fail), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_empty", 64'(con_valid), 64'd0);

    // Watchdog: timeout together with count 101
    wait_cnt(64'd100);
    check("timeout_at_100", 64'(timeout), 64'd0);
    tick();
    check("timeout_cnt", cycle_cnt, 64'd101);
    check("timeout_flag", 64'(timeout), 64'd1);
    check("timeout_done", 64'(done), 64'd1);
    tick();
    check("timeout_frozen", cycle_cnt, 64'd101);

    // Registered hit in the timeout cycle wins
    reset_pulse();
    wait_cnt(64'd99);
    wr(TH0, 32'd1);
    check("prio_cnt100", 64'(timeout), 64'd0);
    tick();
    check("prio_pass", 64'(pass), 64'd1);
    check("prio_no_timeout", 64'(timeout), 64'd0);
    check("prio_cnt", cycle_cnt, 64'd101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zeroriscy_host_if.md
ZERORISCY_HOST_IF -- requirements
Module: zeroriscy_host_if

Synthesizable host-interface monitor. Snoops the core data bus and provides:
- tohost pass/fail detection on several channels
- a buffered console port
- a cycle-timeout watchdog

Interface
REQ-001 SHALL have parameter NUM_TOHOST, default 3, meaning number of tohost channels (1..4).
REQ-002 SHALL have parameter TOHOST_ADDR0..TOHOST_ADDR3, defaults 32'h80001000, 32'h80003000, 32'h8017fffc, 32'h0, meaning per-channel tohost word address; channels >= NUM_TOHOST are unused.
REQ-003 SHALL have parameter CONSOLE_ADDR, default 32'h9a100000, meaning console byte-write address.
REQ-004 SHALL have parameter CON_DEPTH, default 16, meaning console FIFO entries (power of 2, >= 2).
REQ-005 SHALL have parameter MAX_CYCLES, default 64'd0, meaning watchdog limit; 0 disables the watchdog.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 data_req_i  in  1  core data request.
REQ-009 data_we_i  in  1  write enable.
REQ-010 data_be_i  in  4  byte enables.
REQ-011 data_addr_i  in  32  byte address.
REQ-012 data_wdata_i  in  32  write data.
REQ-013 con_valid_o  out  1  console byte available.
REQ-014 con_data_o  out  8  console byte (FIFO head).
REQ-015 con_ready_i  in  1  consumer accepts byte.
REQ-016 done_o  out  1  sticky; state != RUN.
REQ-017 pass_o  out  1  state == PASS.
REQ-018 fail_o  out  1  state == FAIL.
REQ-019 timeout_o  out  1  state == TIMEOUT.
REQ-020 fail_code_o  out  31  captured wdata[31:1] of the failing write.
REQ-021 fail_chan_o  out  2  index of the failing tohost channel.
REQ-022 cycle_cnt_o  out  64  cycles since reset release.
REQ-023 con_drop_o  out  16  dropped console bytes, saturating.

Function
REQ-024 SHALL define a write hit as data_req_i & data_we_i in the same cycle with data_addr_i equal to the target address.
REQ-025 On a tohost hit with data_wdata_i != 0, SHALL register the hit, the data and the channel index at that edge; on duplicate addresses the lowest channel index wins.
REQ-026 SHALL implement FSM states RUN, PASS, FAIL, TIMEOUT; PASS, FAIL and TIMEOUT are terminal until reset.
REQ-027 In RUN, a registered hit with data == 1 SHALL go to PASS at the next edge; a hit in cycle N gives pass_o = 1 from cycle N+2.
REQ-028 In RUN, a registered hit with data != 1 SHALL go to FAIL with the same latency, loading fail_code_o = data[31:1] and fail_chan_o.
REQ-029 A tohost write with data == 0 SHALL be ignored; tohost writes in terminal states SHALL be ignored, and fail_code_o/fail_chan_o SHALL hold.
REQ-030 cycle_cnt_o SHALL increment by 1 every cycle in RUN and freeze on leaving RUN.
REQ-031 With MAX_CYCLES > 0, RUN SHALL go to TIMEOUT at the edge where cycle_cnt_o > MAX_CYCLES; a registered tohost hit in the same cycle SHALL take priority over timeout.
REQ-032 A console hit with data_be_i[0] = 1 SHALL push data_wdata_i[7:0]; data_be_i[0] = 0 SHALL be ignored; console writes are accepted in every FSM state.
REQ-033 Console FIFO pop SHALL occur on con_valid_o & con_ready_i.
REQ-034 con_valid_o SHALL equal FIFO non-empty; con_data_o SHALL be the oldest byte, strictly first-in first-out.
REQ-035 Push when full with a simultaneous pop SHALL be accepted; push when full without a pop SHALL drop the byte and increment con_drop_o, saturating at 16'hFFFF.
REQ-036 Push and pop on an empty FIFO SHALL NOT bypass: the byte becomes visible the next cycle.
REQ-037 FIFO pointers SHALL wrap modulo CON_DEPTH, with one extra bit distinguishing full from empty.

Reset
REQ-038 While rst_ni = 0, all of the following SHALL be 0, regardless of clock:
- state = RUN
- all status outputs
- fail_code_o, fail_chan_o
- cycle_cnt_o, con_drop_o
- FIFO pointers, con_valid_o
- registered hit
REQ-039 Reset asserted mid-operation SHALL discard buffered console bytes and any pending tohost hit.
REQ-040 Deassertion SHALL be synchronised externally; the first count increment SHALL occur at the first rising edge with rst_ni = 1.

Verification
REQ-041 Write 1 to 32'h80001000 in cycle N -> pass_o = done_o = 1 from cycle N+2, cycle_cnt_o frozen.
REQ-042 Write 32'h0000000B to 32'h8017fffc -> fail_o = 1, fail_code_o = 5, fail_chan_o = 2; a later write of 1 leaves FAIL unchanged.
REQ-043 MAX_CYCLES = 100, no writes -> timeout_o = 1 when cycle_cnt_o reaches 101; with a tohost hit registered in that same cycle, PASS/FAIL wins instead.
REQ-044 CON_DEPTH = 4, con_ready_i = 0, write "ABCDEF" -> con_drop_o = 2; raising con_ready_i yields A, B, C, D in order, then con_valid_o = 0.
REQ-045 FIFO full with simultaneous push and pop -> no drop, occupancy stays 4; push with data_be_i = 4'b1110 -> ignored.
REQ-046 Assert rst_ni = 0 with 3 bytes buffered and state FAIL -> all outputs 0 immediately, state RUN.
